// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: IF fetch port (sram-like) to AXI3 read-only master.
// Single-beat in-order fetches; a flush drops responses of older fetches.
module inst_axi_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID_VAL        = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        fetch_cancel,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_e;

  localparam logic [2:0] MAX_Q = 3'(MAX_OUTSTANDING);

  ar_state_e   state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [2:0]  out_q, out_d;
  logic [2:0]  disc_q, disc_d;
  logic        addr_ok;
  logic        r_fire;

  // Write-side and response-tag inputs carry no meaning for fetches.
  logic unused_in;
  assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rid, rresp, rlast};

  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = (state_q == AR_WAIT);

  assign rready            = (out_q != 3'd0);
  assign r_fire            = rvalid && rready;
  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = r_fire && (disc_q == 3'd0);
  assign inst_sram_rdata   = rdata;

  // AR channel: accept one request, then hold it until arready.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    addr_ok  = 1'b0;
    unique case (state_q)
      AR_IDLE: begin
        addr_ok = resetn && inst_sram_req && (out_q < MAX_Q);
        if (addr_ok) begin
          araddr_d = inst_sram_addr;
          arsize_d = {1'b0, inst_sram_size};
          state_d  = AR_WAIT;
        end
      end
      AR_WAIT: begin
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // In-flight count: accepted but not yet answered on R.
  always_comb begin
    out_d = out_q;
    unique case ({addr_ok, r_fire})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase
  end

  // Responses still owed to pre-flush requests; a request accepted in
  // the cancel cycle is not yet in out_q, so it stays deliverable.
  always_comb begin
    disc_d = disc_q;
    if (fetch_cancel) begin
      disc_d = out_q - {2'b00, r_fire};
    end else if (r_fire && (disc_q != 3'd0)) begin
      disc_d = disc_q - 3'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= AR_IDLE;
      araddr_q <= 32'd0;
      arsize_q <= 3'd0;
      out_q    <= 3'd0;
      disc_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
    end
  end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed fetch scenarios with an AXI slave model
// and a response scoreboard of {deliver, data} entries.
module tb_inst_axi_bridge;

  localparam int LAT = 3;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        fetch_cancel;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic        arready_en;
  logic        r_en;
  logic        rvalid_force;
  logic        front_ok;
  logic [31:0] front_data;

  bit          ar_fire_s;
  bit          r_fire_s;
  logic [31:0] araddr_s;

  logic [32:0] exp_q[$];
  logic [31:0] arq_a[$];
  int          arq_t[$];
  int          cyc;

  int n_checks;
  int n_errors;

  assign arready = arready_en;
  assign rvalid  = rvalid_force | (r_en & front_ok);
  assign rdata   = front_data;
  assign rid     = 4'h0;
  assign rresp   = 2'b00;
  assign rlast   = 1'b1;

  inst_axi_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .fetch_cancel      (fetch_cancel),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a == 32'h1c00_0000) ? 32'h0280_0000 : ~a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // Slave model: record AR handshakes, present R in order after LAT.
  initial begin
    front_ok   = 1'b0;
    front_data = 32'd0;
    cyc        = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetn) begin
        arq_a.delete();
        arq_t.delete();
      end else begin
        if (r_fire_s && arq_a.size() != 0) begin
          void'(arq_a.pop_front());
          void'(arq_t.pop_front());
        end
        if (ar_fire_s) begin
          arq_a.push_back(araddr_s);
          arq_t.push_back(cyc);
        end
      end
      #1;
      front_ok = 1'b0;
      if (arq_a.size() != 0) begin
        front_ok   = (cyc >= arq_t[0] + LAT);
        front_data = mem_of(arq_a[0]);
      end
    end
  end

  // Monitor: sample mid-cycle, score each R beat the DUT accepts.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ar_fire_s = 1'b0;
        r_fire_s  = 1'b0;
      end else begin
        ar_fire_s = arvalid && arready;
        araddr_s  = araddr;
        r_fire_s  = rvalid && rready;
        chk("rready", {31'd0, rready}, {31'd0, exp_q.size() != 0});
        if (r_fire_s) begin
          chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("data_ok", {31'd0, inst_sram_data_ok}, {31'd0, e[32]});
            if (e[32]) chk("rdata", inst_sram_rdata, e[31:0]);
          end
        end else begin
          chk("data_ok_idle", {31'd0, inst_sram_data_ok}, 32'd0);
        end
      end
    end
  end

  // Issue one fetch; call and return at posedge+1.
  task automatic do_req(input logic [31:0] a, input bit dlv,
                        input int maxw);
    int n;
    n = 0;
    inst_sram_req  = 1'b1;
    inst_sram_addr = a;
    #1;
    while (!inst_sram_addr_ok && n < maxw) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    @(posedge clk);
    #1;
    if (n < maxw) exp_q.push_back({dlv, mem_of(a)});
    inst_sram_req = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop every queued response from index 'from' on.
  task automatic mark_drop(input int from);
    logic [32:0] t;
    for (int i = from; i < exp_q.size(); i++) begin
      t      = exp_q[i];
      t[32]  = 1'b0;
      exp_q[i] = t;
    end
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    resetn          = 1'b0;
    inst_sram_req   = 1'b1;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'b10;
    inst_sram_addr  = 32'h1c00_0000;
    inst_sram_wstrb = 4'h0;
    inst_sram_wdata = 32'd0;
    fetch_cancel    = 1'b0;
    arready_en      = 1'b1;
    r_en            = 1'b0;
    rvalid_force    = 1'b1;

    // reset with rvalid high and a pending request
    repeat (3) @(posedge clk);
    #2;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", {29'd0, arsize}, 32'd0);
    inst_sram_req = 1'b0;
    rvalid_force  = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    // single fetch, fixed AR attributes, latency
    r_en = 1'b1;
    do_req(32'h1c00_0000, 1'b1, 10);
    #1;
    chk("arvalid_n1", {31'd0, arvalid}, 32'd1);
    chk("araddr", araddr, 32'h1c00_0000);
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);
    chk("arattr", {23'd0, arlock, arcache, arprot}, 32'd0);
    wait_drain(20);

    // outstanding limit
    r_en = 1'b0;
    do_req(32'h1c00_0010, 1'b1, 10);
    do_req(32'h1c00_0014, 1'b1, 10);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0018;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("limit_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
      @(posedge clk);
      #1;
    end
    r_en = 1'b1;
    do_req(32'h1c00_0018, 1'b1, 20);
    wait_drain(30);

    // cancel with two in flight, then a post-flush fetch
    r_en = 1'b0;
    do_req(32'h1c00_0020, 1'b1, 10);
    do_req(32'h1c00_0024, 1'b1, 10);
    fetch_cancel = 1'b1;
    #1;
    mark_drop(rvalid ? 1 : 0);
    @(posedge clk);
    #1;
    fetch_cancel = 1'b0;
    r_en = 1'b1;
    do_req(32'h1c00_8000, 1'b1, 30);
    wait_drain(30);

    // cancel + addr_ok + R beat in one cycle
    r_en = 1'b0;
    do_req(32'h1c00_0030, 1'b1, 10);
    idle(5);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0040;
    fetch_cancel   = 1'b1;
    r_en           = 1'b1;
    #1;
    chk("c5_rvalid", {31'd0, rvalid}, 32'd1);
    chk("c5_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    mark_drop(rvalid ? 1 : 0);
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, mem_of(32'h1c00_0040)});
    inst_sram_req = 1'b0;
    fetch_cancel  = 1'b0;
    wait_drain(30);

    // cancel + addr_ok, no R beat: older fetch dropped
    r_en = 1'b0;
    do_req(32'h1c00_0050, 1'b1, 10);
    idle(5);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0060;
    fetch_cancel   = 1'b1;
    #1;
    chk("c5b_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    mark_drop(rvalid ? 1 : 0);
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, mem_of(32'h1c00_0060)});
    inst_sram_req = 1'b0;
    fetch_cancel  = 1'b0;
    r_en          = 1'b1;
    wait_drain(30);

    // arready stall: payload stable, no new acceptance
    arready_en = 1'b0;
    do_req(32'h1c00_0100, 1'b1, 10);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0200;
    inst_sram_size = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
      chk("stall_araddr", araddr, 32'h1c00_0100);
      chk("stall_arsize", {29'd0, arsize}, 32'd2);
      chk("stall_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
      @(posedge clk);
      #1;
    end
    inst_sram_req  = 1'b0;
    inst_sram_size = 2'b10;
    arready_en     = 1'b1;
    wait_drain(30);
    #1;
    chk("end_arvalid", {31'd0, arvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
